// File: rtl/clock_mode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_mode_ctrl_if
// Description : Front-panel buttons and counter control strobes.
// Revision    : 1.0
// ============================================================================
interface clock_mode_ctrl_if;
    logic       mode_btn;
    logic       field_btn;
    logic       adv_btn;
    logic       alarm_btn;
    logic       timeset;
    logic       alarmset;
    logic       minadv;
    logic       hrsadv;
    logic       dayadv;
    logic       alarmon;
    logic [1:0] mode;
    logic [1:0] field;

    modport master (
        output mode_btn, field_btn, adv_btn, alarm_btn,
        input  timeset, alarmset, minadv, hrsadv, dayadv, alarmon, mode, field
    );

    modport slave (
        input  mode_btn, field_btn, adv_btn, alarm_btn,
        output timeset, alarmset, minadv, hrsadv, dayadv, alarmon, mode, field
    );
endinterface
`default_nettype wire

// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_mode_ctrl
// Description : Mode/field sequencing, auto-repeat advance and idle timeout
//               for the clock/alarm front panel.
// Revision    : 1.0
// ============================================================================
module clock_mode_ctrl #(
    parameter int IDLE_TO = 30,
    parameter int RPT_DLY = 3,
    parameter int RPT_PER = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    clock_mode_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_SET_TIME  = 2'b01,
        ST_SET_ALARM = 2'b10,
        ST_INVALID   = 2'b11
    } mode_t;

    localparam logic [1:0] c_field_min  = 2'b00;
    localparam logic [1:0] c_field_hrs  = 2'b01;
    localparam logic [1:0] c_field_day  = 2'b10;
    localparam logic [7:0] c_idle_to    = 8'(IDLE_TO);
    localparam logic [7:0] c_rpt_dly    = 8'(RPT_DLY);
    localparam logic [7:0] c_rpt_per_m1 = 8'(RPT_PER - 1);

    mode_t      r_mode;
    mode_t      w_mode_nxt;
    logic [1:0] r_field;
    logic [1:0] w_field_nxt;
    logic       r_prev_mode;
    logic       r_prev_field;
    logic       r_prev_adv;
    logic       r_prev_alarm;
    logic [7:0] r_hold;
    logic [7:0] r_phase;
    logic [7:0] w_phase_nxt;
    logic [7:0] r_idle;
    logic [7:0] w_idle_nxt;
    logic       r_armed;
    logic       w_armed_nxt;
    logic       w_fire;
    logic       r_timeset;
    logic       r_alarmset;
    logic       r_minadv;
    logic       r_hrsadv;
    logic       r_dayadv;
    logic       r_alarmon;

    logic w_rise_mode;
    logic w_rise_field;
    logic w_rise_adv;
    logic w_rise_alarm;
    logic w_any_rise;
    logic w_in_set;
    logic w_timeout;
    logic w_rpt_due;

    assign w_rise_mode  = bus.mode_btn  & ~r_prev_mode;
    assign w_rise_field = bus.field_btn & ~r_prev_field;
    assign w_rise_adv   = bus.adv_btn   & ~r_prev_adv;
    assign w_rise_alarm = bus.alarm_btn & ~r_prev_alarm;
    assign w_any_rise   = w_rise_mode | w_rise_field | w_rise_adv | w_rise_alarm;
    assign w_in_set     = (r_mode == ST_SET_TIME) || (r_mode == ST_SET_ALARM);
    assign w_timeout    = w_in_set && (r_idle == c_idle_to);
    // Phase is counted separately from the saturating hold count so repeats never stop
    assign w_rpt_due    = (r_hold >= c_rpt_dly) && (r_phase == 8'd0);

    always_comb begin
        w_mode_nxt  = r_mode;
        w_field_nxt = r_field;
        w_fire      = 1'b0;
        w_armed_nxt = r_armed & bus.adv_btn;
        w_phase_nxt = 8'd0;
        w_idle_nxt  = 8'd0;

        case (r_mode)
            ST_RUN: begin
                if (w_rise_mode) begin
                    w_mode_nxt  = ST_SET_TIME;
                    w_field_nxt = c_field_min;
                end
            end
            ST_SET_TIME, ST_SET_ALARM: begin
                if (w_rise_mode) begin
                    if (r_mode == ST_SET_TIME) begin
                        w_mode_nxt = ST_SET_ALARM;
                    end else begin
                        w_mode_nxt = ST_RUN;
                    end
                    w_field_nxt = c_field_min;
                    w_armed_nxt = 1'b0;
                end else if (w_timeout) begin
                    w_mode_nxt  = ST_RUN;
                    w_field_nxt = c_field_min;
                    w_armed_nxt = 1'b0;
                end else if (w_rise_field) begin
                    if (r_field == c_field_min) begin
                        w_field_nxt = c_field_hrs;
                    end else if (r_field == c_field_hrs) begin
                        w_field_nxt = c_field_day;
                    end else begin
                        w_field_nxt = c_field_min;
                    end
                    w_armed_nxt = 1'b0;
                end else if (w_rise_adv) begin
                    w_fire      = 1'b1;
                    w_armed_nxt = 1'b1;
                end else if (r_armed && bus.adv_btn && w_rpt_due) begin
                    w_fire = 1'b1;
                end
            end
            default: begin
                w_mode_nxt  = ST_RUN;
                w_field_nxt = c_field_min;
                w_armed_nxt = 1'b0;
            end
        endcase

        if (bus.adv_btn && (r_hold >= c_rpt_dly)) begin
            w_phase_nxt = (r_phase == c_rpt_per_m1) ? 8'd0 : r_phase + 8'd1;
        end

        if (w_in_set && (w_mode_nxt != ST_RUN) && !w_any_rise && !bus.adv_btn) begin
            w_idle_nxt = r_idle + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mode       <= ST_RUN;
            r_field      <= c_field_min;
            r_prev_mode  <= 1'b1;
            r_prev_field <= 1'b1;
            r_prev_adv   <= 1'b1;
            r_prev_alarm <= 1'b1;
            r_hold       <= 8'd0;
            r_phase      <= 8'd0;
            r_idle       <= 8'd0;
            r_armed      <= 1'b0;
            r_timeset    <= 1'b0;
            r_alarmset   <= 1'b0;
            r_minadv     <= 1'b0;
            r_hrsadv     <= 1'b0;
            r_dayadv     <= 1'b0;
            r_alarmon    <= 1'b0;
        end else begin
            r_mode       <= w_mode_nxt;
            r_field      <= w_field_nxt;
            r_prev_mode  <= bus.mode_btn;
            r_prev_field <= bus.field_btn;
            r_prev_adv   <= bus.adv_btn;
            r_prev_alarm <= bus.alarm_btn;
            if (bus.adv_btn) begin
                r_hold <= (r_hold == 8'hFF) ? r_hold : r_hold + 8'd1;
            end else begin
                r_hold <= 8'd0;
            end
            r_phase      <= w_phase_nxt;
            r_idle       <= w_idle_nxt;
            r_armed      <= w_armed_nxt;
            r_timeset    <= (w_mode_nxt == ST_SET_TIME);
            r_alarmset   <= (w_mode_nxt == ST_SET_ALARM);
            r_minadv     <= w_fire && (r_field == c_field_min);
            r_hrsadv     <= w_fire && (r_field == c_field_hrs);
            r_dayadv     <= w_fire && (r_field == c_field_day);
            r_alarmon    <= r_alarmon ^ w_rise_alarm;
        end
    end

    assign bus.mode     = r_mode;
    assign bus.field    = r_field;
    assign bus.timeset  = r_timeset;
    assign bus.alarmset = r_alarmset;
    assign bus.minadv   = r_minadv;
    assign bus.hrsadv   = r_hrsadv;
    assign bus.dayadv   = r_dayadv;
    assign bus.alarmon  = r_alarmon;

endmodule
`default_nettype wire

// File: tb/tb_clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_mode_ctrl
// Description : Vector table, directed corner sequences and random stimulus
//               against a behavioural panel model.
// Revision    : 1.0
// ============================================================================
module tb_clock_mode_ctrl;

    localparam int IDLE_TO = 30;
    localparam int RPT_DLY = 3;
    localparam int RPT_PER = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clock_mode_ctrl_if bus();

    clock_mode_ctrl #(
        .IDLE_TO(IDLE_TO),
        .RPT_DLY(RPT_DLY),
        .RPT_PER(RPT_PER)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic       rstn;
        logic [3:0] btn;   // {mode, field, adv, alarm}
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Model state: plain integers, consecutive-hold count is unbounded
    int         m_mode, m_field, m_hold, m_idle, m_sel;
    bit         m_rep, m_alm;
    logic [3:0] m_prev;

    function automatic logic [9:0] mk(int md, int fd, int sel, bit alm);
        logic [1:0] m2, f2;
        m2 = md[1:0];
        f2 = fd[1:0];
        return {m2, f2, md == 1, md == 2, sel == 0, sel == 1, sel == 2, alm};
    endfunction

    function automatic vec_t v(logic r, logic [3:0] b, int md, int fd, int sel, bit alm);
        vec_t t;
        t.rstn = r;
        t.btn  = b;
        t.exp  = mk(md, fd, sel, alm);
        return t;
    endfunction

    function automatic logic [9:0] dut_out();
        return {bus.mode, bus.field, bus.timeset, bus.alarmset,
                bus.minadv, bus.hrsadv, bus.dayadv, bus.alarmon};
    endfunction

    task automatic model_step(input logic rn, input logic [3:0] b);
        logic [3:0] rise;
        bit         adv, set, tmo;
        int         j;
        if (!rn) begin
            m_mode = 0; m_field = 0; m_hold = 0; m_idle = 0; m_sel = -1;
            m_rep = 0; m_alm = 0; m_prev = 4'hF;
        end else begin
            rise  = b & ~m_prev;
            adv   = b[1];
            j     = m_hold;
            set   = (m_mode != 0);
            tmo   = set && (m_idle >= IDLE_TO);
            m_sel = -1;
            if (rise[0]) m_alm = !m_alm;
            if (rise[3]) begin
                m_mode = (m_mode + 1) % 3; m_field = 0; m_rep = 0;
            end else if (tmo) begin
                m_mode = 0; m_field = 0; m_rep = 0;
            end else if (set && rise[2]) begin
                m_field = (m_field + 1) % 3; m_rep = 0;
            end else if (set && rise[1]) begin
                m_sel = m_field; m_rep = 1;
            end else if (set && m_rep && adv && j >= RPT_DLY && ((j - RPT_DLY) % RPT_PER) == 0) begin
                m_sel = m_field;
            end
            if (!adv) m_rep = 0;
            if (!set || m_mode == 0 || rise != 4'b0 || adv) m_idle = 0;
            else m_idle = m_idle + 1;
            m_hold = adv ? j + 1 : 0;
            m_prev = b;
        end
    endtask

    task automatic drive(input logic rn, input logic [3:0] b);
        @(negedge clk);
        rst = rn;
        {bus.mode_btn, bus.field_btn, bus.adv_btn, bus.alarm_btn} = b;
        @(posedge clk);
        #1;
        model_step(rn, b);
    endtask

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] got;
        got = dut_out();
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b (mode,field,ts,as,min,hrs,day,alm)", name, got, exp);
        end
    endtask

    task automatic exp_chk(input string name, input logic rn, input logic [3:0] b,
                           input int md, input int fd, input int sel, input bit alm);
        drive(rn, b);
        check(name, mk(md, fd, sel, alm));
    endtask

    task automatic step_chk(input string name, input logic rn, input logic [3:0] b);
        drive(rn, b);
        check(name, mk(m_mode, m_field, m_sel, m_alm));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] b;
        logic       rn;
        int         style, len;

        rst = 1'b0;
        {bus.mode_btn, bus.field_btn, bus.adv_btn, bus.alarm_btn} = 4'hF;
        model_step(1'b0, 4'hF);

        // Reset with buttons held, mode cycling, alarm toggling, field select
        tbl.push_back(v(0, 4'b1111, 0, 0, -1, 0));
        tbl.push_back(v(0, 4'b1111, 0, 0, -1, 0));
        tbl.push_back(v(1, 4'b1111, 0, 0, -1, 0));
        tbl.push_back(v(1, 4'b0000, 0, 0, -1, 0));
        tbl.push_back(v(1, 4'b1000, 1, 0, -1, 0));
        tbl.push_back(v(1, 4'b0000, 1, 0, -1, 0));
        tbl.push_back(v(1, 4'b1000, 2, 0, -1, 0));
        tbl.push_back(v(1, 4'b0000, 2, 0, -1, 0));
        tbl.push_back(v(1, 4'b1000, 0, 0, -1, 0));
        tbl.push_back(v(1, 4'b0000, 0, 0, -1, 0));
        tbl.push_back(v(1, 4'b0001, 0, 0, -1, 1));
        tbl.push_back(v(1, 4'b0000, 0, 0, -1, 1));
        tbl.push_back(v(1, 4'b1000, 1, 0, -1, 1));
        tbl.push_back(v(1, 4'b0100, 1, 1, -1, 1));
        tbl.push_back(v(1, 4'b0001, 1, 1, -1, 0));
        tbl.push_back(v(1, 4'b0000, 1, 1, -1, 0));
        tbl.push_back(v(1, 4'b1000, 2, 0, -1, 0));
        tbl.push_back(v(1, 4'b0001, 2, 0, -1, 1));
        tbl.push_back(v(1, 4'b0000, 2, 0, -1, 1));
        tbl.push_back(v(1, 4'b1000, 0, 0, -1, 1));
        tbl.push_back(v(1, 4'b0100, 0, 0, -1, 1));
        tbl.push_back(v(1, 4'b0000, 0, 0, -1, 1));
        // mode and adv rising together
        tbl.push_back(v(1, 4'b1000, 1, 0, -1, 1));
        tbl.push_back(v(1, 4'b0000, 1, 0, -1, 1));
        tbl.push_back(v(1, 4'b1000, 2, 0, -1, 1));
        tbl.push_back(v(1, 4'b0000, 2, 0, -1, 1));
        tbl.push_back(v(1, 4'b1010, 0, 0, -1, 1));
        tbl.push_back(v(1, 4'b0010, 0, 0, -1, 1));
        tbl.push_back(v(1, 4'b0000, 0, 0, -1, 1));
        tbl.push_back(v(1, 4'b1000, 1, 0, -1, 1));
        tbl.push_back(v(1, 4'b0000, 1, 0, -1, 1));
        tbl.push_back(v(1, 4'b1010, 2, 0, -1, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(v(1, 4'b0010, 2, 0, -1, 1));
        tbl.push_back(v(1, 4'b0000, 2, 0, -1, 1));
        tbl.push_back(v(1, 4'b0010, 2, 0, 0, 1));
        tbl.push_back(v(1, 4'b0000, 2, 0, -1, 1));
        tbl.push_back(v(1, 4'b1000, 0, 0, -1, 1));
        tbl.push_back(v(1, 4'b0000, 0, 0, -1, 1));
        // field and adv rising together, then DAY advance and field wrap
        tbl.push_back(v(1, 4'b1000, 1, 0, -1, 1));
        tbl.push_back(v(1, 4'b0000, 1, 0, -1, 1));
        tbl.push_back(v(1, 4'b0110, 1, 1, -1, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(v(1, 4'b0010, 1, 1, -1, 1));
        tbl.push_back(v(1, 4'b0000, 1, 1, -1, 1));
        tbl.push_back(v(1, 4'b0100, 1, 2, -1, 1));
        tbl.push_back(v(1, 4'b0000, 1, 2, -1, 1));
        tbl.push_back(v(1, 4'b0010, 1, 2, 2, 1));
        tbl.push_back(v(1, 4'b0000, 1, 2, -1, 1));
        tbl.push_back(v(1, 4'b0100, 1, 0, -1, 1));
        tbl.push_back(v(1, 4'b0000, 1, 0, -1, 1));
        tbl.push_back(v(1, 4'b1000, 2, 0, -1, 1));
        tbl.push_back(v(1, 4'b0000, 2, 0, -1, 1));
        tbl.push_back(v(1, 4'b1000, 0, 0, -1, 1));
        tbl.push_back(v(1, 4'b0000, 0, 0, -1, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rstn, tbl[i].btn);
            check($sformatf("tbl%0d", i), tbl[i].exp);
        end

        // Auto-repeat on HRS: strobes at 1,4,5,6,7,8 after the press
        exp_chk("rpt_enter", 1, 4'b1000, 1, 0, -1, 1);
        exp_chk("rpt_rel0", 1, 4'b0000, 1, 0, -1, 1);
        exp_chk("rpt_field", 1, 4'b0100, 1, 1, -1, 1);
        exp_chk("rpt_rel1", 1, 4'b0000, 1, 1, -1, 1);
        for (int k = 0; k < 8; k++)
            exp_chk($sformatf("rpt_hold%0d", k + 1), 1, 4'b0010, 1, 1, (k == 0 || k >= 3) ? 1 : -1, 1);
        exp_chk("rpt_release", 1, 4'b0000, 1, 1, -1, 1);
        exp_chk("rpt_exit0", 1, 4'b1000, 2, 0, -1, 1);
        exp_chk("rpt_exit1", 1, 4'b0000, 2, 0, -1, 1);
        exp_chk("rpt_exit2", 1, 4'b1000, 0, 0, -1, 1);
        exp_chk("rpt_exit3", 1, 4'b0000, 0, 0, -1, 1);

        // Idle timeout with no activity
        exp_chk("to1_enter", 1, 4'b1000, 1, 0, -1, 1);
        for (int k = 1; k <= 31; k++)
            exp_chk($sformatf("to1_c%0d", k), 1, 4'b0000, (k == 31) ? 0 : 1, 0, -1, 1);

        // Idle timeout restarted by an advance press at cycle 20
        exp_chk("to2_enter", 1, 4'b1000, 1, 0, -1, 1);
        for (int k = 1; k <= 51; k++)
            exp_chk($sformatf("to2_c%0d", k), 1, (k == 20) ? 4'b0010 : 4'b0000,
                    (k == 51) ? 0 : 1, 0, (k == 20) ? 0 : -1, 1);

        // Mode press on the timeout cycle advances the FSM instead
        exp_chk("to3_enter", 1, 4'b1000, 1, 0, -1, 1);
        for (int k = 1; k <= 30; k++)
            exp_chk($sformatf("to3_c%0d", k), 1, 4'b0000, 1, 0, -1, 1);
        exp_chk("to3_mode", 1, 4'b1000, 2, 0, -1, 1);
        exp_chk("to3_rel", 1, 4'b0000, 2, 0, -1, 1);
        exp_chk("to3_run", 1, 4'b1000, 0, 0, -1, 1);
        exp_chk("to3_rel2", 1, 4'b0000, 0, 0, -1, 1);

        // Reset in the middle of auto-repeat
        exp_chk("rr_enter", 1, 4'b1000, 1, 0, -1, 1);
        exp_chk("rr_rel", 1, 4'b0000, 1, 0, -1, 1);
        exp_chk("rr_h1", 1, 4'b0010, 1, 0, 0, 1);
        exp_chk("rr_h2", 1, 4'b0010, 1, 0, -1, 1);
        exp_chk("rr_h3", 1, 4'b0010, 1, 0, -1, 1);
        exp_chk("rr_h4", 1, 4'b0010, 1, 0, 0, 1);
        exp_chk("rr_reset", 0, 4'b0010, 0, 0, -1, 0);
        exp_chk("rr_post1", 1, 4'b0010, 0, 0, -1, 0);
        exp_chk("rr_post2", 1, 4'b0010, 0, 0, -1, 0);
        exp_chk("rr_post3", 1, 4'b0000, 0, 0, -1, 0);
        exp_chk("rr_set", 1, 4'b1000, 1, 0, -1, 0);
        exp_chk("rr_adv", 1, 4'b0010, 1, 0, 0, 0);
        exp_chk("rr_rel2", 1, 4'b0000, 1, 0, -1, 0);
        exp_chk("rr_x0", 1, 4'b1000, 2, 0, -1, 0);
        exp_chk("rr_x1", 1, 4'b0000, 2, 0, -1, 0);
        exp_chk("rr_x2", 1, 4'b1000, 0, 0, -1, 0);
        exp_chk("rr_x3", 1, 4'b0000, 0, 0, -1, 0);

        // Long hold on DAY past hold-counter saturation
        step_chk("sat_enter", 1, 4'b1000);
        step_chk("sat_r0", 1, 4'b0000);
        step_chk("sat_f1", 1, 4'b0100);
        step_chk("sat_r1", 1, 4'b0000);
        step_chk("sat_f2", 1, 4'b0100);
        step_chk("sat_r2", 1, 4'b0000);
        for (int k = 0; k < 300; k++)
            step_chk($sformatf("sat_h%0d", k), 1, 4'b0010);
        step_chk("sat_rel", 1, 4'b0000);

        // Random bursts against the model
        for (int n = 0; n < 120; n++) begin
            style = $urandom_range(0, 3);
            len   = $urandom_range(1, 40);
            for (int k = 0; k < len; k++) begin
                case (style)
                    0:       b = 4'b0000;
                    1:       b = {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
                    2:       b = {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                                  1'b1, 1'b0};
                    default: b = 4'($urandom_range(0, 15));
                endcase
                rn = ($urandom_range(0, 299) != 0);
                step_chk($sformatf("rnd%0d_%0d", n, k), rn, b);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- Front-panel controller for the digital clock/alarm datapath.
- Converts four synchronized push-buttons into the control strobes the time and alarm counters consume: timeset, alarmset, minadv, hrsadv, dayadv and alarmon.
- Provides mode sequencing, field selection, auto-repeat advance and an inactivity timeout back to run mode.
- Clocked by the same 1-cycle/sec pulse that drives the counters.

Parameters:
IDLE_TO, 30, consecutive inactive cycles in a set mode before forcing return to RUN (legal 1..255)
RPT_DLY, 3, cycles adv_btn must stay held after the first advance before auto-repeat starts (legal 1..255)
RPT_PER, 1, cycles between auto-repeat advances (legal 1..255)

Ports:
clk  input  1  system clock (1 cycle/sec pulse)
rst  input  1  synchronous, active-low reset
mode_btn  input  1  mode button level, already synchronized
field_btn  input  1  field-select button level
adv_btn  input  1  advance button level
alarm_btn  input  1  alarm enable toggle button level
timeset  output  1  high while in SET_TIME
alarmset  output  1  high while in SET_ALARM
minadv  output  1  one-cycle advance strobe, minutes
hrsadv  output  1  one-cycle advance strobe, hours
dayadv  output  1  one-cycle advance strobe, days
alarmon  output  1  alarm enable level
mode  output  2  00 RUN, 01 SET_TIME, 10 SET_ALARM
field  output  2  00 MIN, 01 HRS, 10 DAY; 00 in RUN

Behaviour:
- All outputs registered; all state updates on rising clk.
- Reset (rst low at an edge):
  - mode=RUN, field=MIN; timeset/alarmset/adv strobes/alarmon=0; all counters=0.
  - Per-button previous-level registers load 1, so a button held through reset must be released before it registers.
- Edge detect: rise_x = x & ~prev_x, evaluated on the sampled input.
  - Actions take effect in the cycle after the edge at which the rise is sampled (1-cycle latency).
- Mode FSM (advances on rise_mode only):
  - RUN -> SET_TIME -> SET_ALARM -> RUN.
  - Entering any set mode loads field=MIN.
  - Encoding 11 is unreachable; if reached, go to RUN next cycle.
- timeset = (mode==SET_TIME); alarmset = (mode==SET_ALARM). They change in the same cycle as mode.
- Field select: rise_field in a set mode steps MIN -> HRS -> DAY -> MIN. rise_field in RUN is ignored.
- Advance:
  - Only in set modes.
  - rise_adv produces exactly one strobe on the output for the current field (minadv/hrsadv/dayadv) in the next cycle.
  - At most one strobe is high in any cycle.
- Auto-repeat:
  - While adv_btn stays high, an 8-bit hold counter increments each cycle.
  - The first repeat strobe occurs RPT_DLY cycles after the initial strobe; further strobes every RPT_PER cycles.
  - Counter clears when adv_btn is low.
- Priority in the same cycle: rise_mode > rise_field > advance.
  - A suppressed advance is not deferred.
  - After any mode or field change, auto-repeat stays inhibited until adv_btn is released and pressed again.
- Idle timeout:
  - In a set mode, an 8-bit idle counter clears on any button rise or while adv_btn is high; otherwise it increments.
  - On reaching IDLE_TO: next cycle mode=RUN, field=MIN, no strobe.
  - In RUN the counter holds 0.
  - A rise_mode in the same cycle as timeout takes priority: the FSM advances normally.
- Alarm toggle: rise_alarm toggles alarmon in any mode, independent of the FSM and of the other buttons.
- Reset mid-operation (mid-repeat or mid-set): all state returns to reset values at that edge; no strobe in the following cycle.
- Counter wrap: hold counter saturates at 255. Repeat timing uses the phase relative to RPT_DLY, so strobes continue indefinitely at RPT_PER.

Test Plan:
- Reset with all buttons high, release rst -> mode=00, alarmon=0; no action until buttons drop and rise again.
- Three mode_btn presses (1 cycle each, 2 cycles apart) -> mode 01, 10, 00; timeset high only in 01, alarmset high only in 10.
- SET_TIME, field_btn once, adv_btn held 8 cycles (RPT_DLY=3, RPT_PER=1) -> hrsadv high at cycles 1,4,5,6,7,8 after the press; minadv and dayadv stay 0.
- SET_ALARM, mode_btn and adv_btn rise together -> mode=RUN, no adv strobe; adv_btn kept held gives no repeat strobes.
- SET_TIME, no buttons for 30 cycles (IDLE_TO=30) -> mode=RUN on cycle 31. Repeat with an adv press at cycle 20 -> timeout at cycle 51.
- alarm_btn pressed in RUN, SET_TIME and SET_ALARM -> alarmon toggles 1, 0, 1; mode and field unaffected.
